// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out transmitter, MSB-first, with
// first/last framing strobes and a valid/ready load handshake.
// Optional feature macro: SER_CRC_APPEND_EN appends a 3-bit CRC
// (x^3+x+1) after the data bits of every frame.
module piso_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic              sout,
  output logic              sout_valid,
  output logic              sout_first,
  output logic              sout_last,
  output logic              busy
);

`ifdef SER_CRC_APPEND_EN
  localparam int F = DATA_W + 3;
`else
  localparam int F = DATA_W;
`endif
  localparam int CW = (F > 1) ? $clog2(F) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
`ifdef SER_CRC_APPEND_EN
    ,ST_CRC  = 2'd2
`endif
  } state_t;

  state_t            state, state_d;
  logic [DATA_W-1:0] sreg, sreg_d;   // bits still to go; current bit is in sout
  logic [CW-1:0]     cnt, cnt_d;     // index within the frame of the bit on sout
  logic              sout_d, vld_d, first_d, last_d;
  logic              accept;

`ifdef SER_CRC_APPEND_EN
  logic [2:0] crc, crc_d, crc_nx;

  function automatic logic [2:0] crc_upd(input logic [2:0] c, input logic b);
    logic fb;
    fb = b ^ c[2];
    return {c[1], c[0] ^ fb, fb};
  endfunction
`endif

  // ready depends on registered state only, never on load_valid
  assign load_ready = (state == ST_IDLE) | (sout_valid & sout_last);
  assign accept     = load_valid & load_ready;
  assign busy       = sout_valid;

  // next-state and next-output decode; an accept overrides the frame tail
  always_comb begin
    state_d = state;
    sreg_d  = sreg;
    cnt_d   = cnt;
    sout_d  = 1'b0;
    vld_d   = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
`ifdef SER_CRC_APPEND_EN
    crc_d   = crc;
    crc_nx  = crc_upd(crc, sout);
`endif
    case (state)
      ST_IDLE: ;
      ST_SHIFT: begin
        if (cnt != CW'(DATA_W - 1)) begin
          sout_d = sreg[DATA_W-1];
          sreg_d = {sreg[DATA_W-2:0], 1'b0};
          cnt_d  = cnt + 1'b1;
          vld_d  = 1'b1;
          last_d = (cnt + 1'b1 == CW'(F - 1));
`ifdef SER_CRC_APPEND_EN
          crc_d  = crc_nx;
`endif
        end else begin
`ifdef SER_CRC_APPEND_EN
          // fold the final data bit, then start sending the check bits
          state_d = ST_CRC;
          sout_d  = crc_nx[2];
          crc_d   = {crc_nx[1:0], 1'b0};
          cnt_d   = cnt + 1'b1;
          vld_d   = 1'b1;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef SER_CRC_APPEND_EN
      ST_CRC: begin
        if (cnt != CW'(F - 1)) begin
          sout_d = crc[2];
          crc_d  = {crc[1:0], 1'b0};
          cnt_d  = cnt + 1'b1;
          vld_d  = 1'b1;
          last_d = (cnt + 1'b1 == CW'(F - 1));
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d = ST_SHIFT;
      sout_d  = load_data[DATA_W-1];
      sreg_d  = {load_data[DATA_W-2:0], 1'b0};
      cnt_d   = '0;
      vld_d   = 1'b1;
      first_d = 1'b1;
      last_d  = 1'b0;
`ifdef SER_CRC_APPEND_EN
      crc_d   = 3'b000;
`endif
    end
  end

  // state, datapath and registered outputs; reset aborts any frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sreg       <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_first <= 1'b0;
      sout_last  <= 1'b0;
`ifdef SER_CRC_APPEND_EN
      crc        <= 3'b000;
`endif
    end else begin
      state      <= state_d;
      sreg       <= sreg_d;
      cnt        <= cnt_d;
      sout       <= sout_d;
      sout_valid <= vld_d;
      sout_first <= first_d;
      sout_last  <= last_d;
`ifdef SER_CRC_APPEND_EN
      crc        <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: random and directed stimulus against a
// frame-level reference model (bit list per word, CRC by polynomial division).
module tb_piso_serializer;
  localparam int DW = 8;
`ifdef SER_CRC_APPEND_EN
  localparam int F = DW + 3;
`else
  localparam int F = DW;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_ready, sout, sout_valid, sout_first, sout_last, busy;

  piso_serializer #(.DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .sout(sout), .sout_valid(sout_valid),
    .sout_first(sout_first), .sout_last(sout_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: current frame as a list of bits plus position
  int   fr[$];
  int   m_pos = 0;
  bit   m_act = 0;
  logic [31:0] cap;

  // remainder of data(x)*x^3 divided by x^3+x+1
  function automatic logic [2:0] ref_crc(input logic [DW-1:0] d);
    logic [DW+2:0] v;
    v = {d, 3'b000};
    for (int i = DW + 2; i >= 3; i--)
      if (v[i]) v = v ^ ((DW+3)'(4'b1011) << (i - 3));
    return v[2:0];
  endfunction

  function automatic bit m_ready();
    return !m_act || (m_pos == F - 1);
  endfunction

  task automatic cyc(input logic r, input logic v, input logic [DW-1:0] d);
    bit acc;
    logic [2:0] c;
    rst_n = r; load_valid = v; load_data = d;
    @(posedge clk);
    if (!r) begin
      m_act = 0; m_pos = 0;
    end else begin
      acc = v && m_ready();
      if (m_act) begin
        m_pos++;
        if (m_pos == F) m_act = 0;
      end
      if (acc) begin
        fr.delete();
        for (int i = DW - 1; i >= 0; i--) fr.push_back(int'(d[i]));
`ifdef SER_CRC_APPEND_EN
        c = ref_crc(d);
        for (int i = 2; i >= 0; i--) fr.push_back(int'(c[i]));
`else
        c = 3'b000;
`endif
        m_pos = 0; m_act = 1;
      end
    end
    #1;
    if (m_act) cap = {cap[30:0], sout};
    chk("valid", 32'(sout_valid), 32'(m_act));
    chk("busy",  32'(busy),       32'(m_act));
    chk("sout",  32'(sout),       m_act ? 32'(fr[m_pos]) : 32'd0);
    chk("first", 32'(sout_first), 32'(m_act && m_pos == 0));
    chk("last",  32'(sout_last),  32'(m_act && m_pos == F - 1));
    chk("ready", 32'(load_ready), 32'(m_ready()));
  endtask

  initial begin
    logic [31:0] exp_a5;
`ifdef SER_CRC_APPEND_EN
    exp_a5 = 32'b10100101101;
`else
    exp_a5 = 32'hA5;
`endif
    // reset held 3 cycles, then idle
    repeat (3) cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    chk("rst_ready", 32'(load_ready), 32'd1);
    // single word A5
    cap = '0;
    cyc(1'b1, 1'b1, 8'hA5);
    repeat (F + 1) cyc(1'b1, 1'b0, '0);
    chk("a5_pattern", cap & ((32'd1 << F) - 1), exp_a5);
    // back-to-back FF then 00 with valid held
    cyc(1'b1, 1'b1, 8'hFF);
    repeat (F) cyc(1'b1, 1'b1, 8'h00);
    repeat (F + 2) cyc(1'b1, 1'b0, '0);
    // backpressure: 3C offered mid-frame, held until taken
    cyc(1'b1, 1'b1, 8'hA5);
    repeat (3) cyc(1'b1, 1'b0, '0);
    for (int i = 0; i < 2 * F; i++) begin
      bit rdy;
      rdy = m_ready();
      cyc(1'b1, 1'b1, 8'h3C);
      if (rdy) break;
    end
    repeat (F + 2) cyc(1'b1, 1'b0, '0);
    // reset mid-frame, then a clean 81
    cyc(1'b1, 1'b1, 8'hA5);
    repeat (3) cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    chk("midrst_valid", 32'(sout_valid), 32'd0);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 8'h81);
    repeat (F + 2) cyc(1'b1, 1'b0, '0);
    // random traffic with occasional resets
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 2) != 0), DW'($urandom));
    repeat (F + 2) cyc(1'b1, 1'b0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out transmitter for the memory-access datapath: the transmit end of the serial bit stream that the serial-in/parallel-out left-shift stage consumes. It accepts a `DATA_W`-bit word through a valid/ready handshake and emits it MSB-first, one bit per clock, with framing strobes. It can optionally append a 3-bit CRC so the receive side can check the frame.

## Interface
- Clock and reset: one clock; reset is synchronous and active-low.

Parameters:
- `DATA_W`, default 8: word width in bits; legal range 2 to 32.

Ports:
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `rst_n`, input, 1: synchronous active-low reset.
- `load_valid`, input, 1: `load_data` is valid.
- `load_ready`, output, 1: the block can accept a word this cycle.
- `load_data`, input, `DATA_W`: word to serialize.
- `sout`, output, 1: serial data bit; driven 0 whenever `sout_valid` = 0.
- `sout_valid`, output, 1: `sout` carries a frame bit this cycle.
- `sout_first`, output, 1: the current bit is the first bit of a frame.
- `sout_last`, output, 1: the current bit is the last bit of a frame.
- `busy`, output, 1: a frame is in progress; equals `sout_valid`.

## Operation
- States:
  - IDLE: no frame in progress.
  - SHIFT: data bits going out.
  - CRC: appended check bits going out; exists only with `SER_CRC_APPEND_EN`.
- Accept: a word is accepted on a rising edge where `load_valid` = 1 and `load_ready` = 1.
  - `load_data` is captured into the shift register.
  - The bit counter loads to 0.
  - The state goes to SHIFT.
- `load_ready` is decoded from registered state only: `load_ready` = IDLE, or (`sout_valid` and `sout_last`). It is never a function of `load_valid`.
- SHIFT:
  - `sout` = shift_reg[`DATA_W`-1].
  - Each cycle the register shifts left by one and fills with 0; the counter increments.
  - After bit `DATA_W`-1:
    - with the CRC option, go to CRC;
    - without it, go to IDLE, or straight back to SHIFT if a new word is accepted in that cycle.
- CRC state: emit crc[2], crc[1], crc[0] over 3 cycles. Then go to IDLE, or to SHIFT if a word is accepted on the last CRC bit.
- CRC arithmetic:
  - Polynomial x^3+x+1; register initialises to 3'b000 at every accept.
  - Per data bit b: fb = b ^ crc[2]; crc <= {crc[1], crc[0]^fb, fb}.
  - Only data bits update the CRC; CRC bits do not feed back.
- `load_valid` while `load_ready` = 0 is ignored. No word is stored, and the upstream must hold its data.
- Reset with `rst_n` = 0 at any point, including mid-frame:
  - the frame is aborted; partial frames are never resumed;
  - state = IDLE; shift register, counter and CRC = 0;
  - `sout`, `sout_valid`, `sout_first`, `sout_last`, `busy` = 0;
  - `load_ready` = 1 from the first cycle after reset is released.

## Timing
- An accept at edge k gives:
  - `sout_valid` = 1 for cycles k+1 through k+F;
  - `sout_first` = 1 only at k+1;
  - `sout_last` = 1 only at k+F.
- F = `DATA_W`, or `DATA_W`+3 with `SER_CRC_APPEND_EN`.
- Latency from accept to first bit: 1 cycle.
- Back-to-back: an accept during the `sout_last` cycle makes the next frame's `sout_first` the very next cycle, with zero bubble.
- Sustained throughput: one word per F cycles.
- All outputs except `load_ready` are registered.

## Configuration
- `SER_CRC_APPEND_EN` defined:
  - the CRC state and register are compiled in;
  - each frame is `DATA_W`+3 bits, with the CRC sent MSB-first after the data;
  - `sout_last` marks crc[0].
- `SER_CRC_APPEND_EN` undefined:
  - no CRC logic;
  - frame is `DATA_W` bits and `sout_last` marks the data LSB.

## Test plan
- Reset, then idle: hold `rst_n` = 0 for 3 cycles, then release → all outputs 0 and `load_ready` = 1 on the first cycle after release.
- Single word: `DATA_W` = 8, `load_data` = 8'hA5, no CRC → `sout` = 1,0,1,0,0,1,0,1 on cycles k+1..k+8; `sout_first` at k+1; `sout_last` at k+8; IDLE at k+9.
- CRC append: `SER_CRC_APPEND_EN`, `load_data` = 8'hA5 → 11 bits: 10100101 followed by 101; `sout_last` only on the 11th bit.
- Back-to-back: hold `load_valid` = 1 with 8'hFF then 8'h00 → 16 contiguous valid cycles, pattern eight 1s then eight 0s, no gap; `sout_first` at bits 1 and 9.
- Backpressure: assert `load_valid` with 8'h3C mid-frame → ignored until the `sout_last` cycle; accepted there; 8'h3C starts the next cycle.
- Reset mid-frame: drive `rst_n` low at bit 4 of 8'hA5 → all outputs 0 the next cycle; after release a new word 8'h81 emits cleanly from its first bit.
